// File: rtl/onehot_drv_pkg.sv
// Shared types and decode function for the one-hot driver.
// ONEHOT_DRV_THERMO_EN selects the thermometer decode in the top; the decode_code()
// function always supports both modes.
package onehot_drv_pkg;

    localparam int unsigned CODE_W = 8;
    localparam int unsigned OUT_W = 16;
    localparam logic [CODE_W-1:0] CODE_NONE = 8'hF0;

    typedef enum logic {IDLE, HOLD} state_e;

    typedef struct packed {
        logic [OUT_W-1:0] pattern;
        logic             illegal;
    } decode_t;

    // Legal codes 0x00-0x0F map to one bit, or to bits [k:0] in thermometer mode.
    // CODE_NONE and illegal codes both produce an all-zero pattern.
    function automatic decode_t decode_code(input logic [CODE_W-1:0] code, input logic thermo);
        decode_t res;
        res.pattern = '0;
        res.illegal = 1'b0;
        if (code[CODE_W-1:4] == '0) begin
            for (int i = 0; i < OUT_W; i++) begin
                res.pattern[i] = thermo ? (4'(i) <= code[3:0]) : (4'(i) == code[3:0]);
            end
        end else if (code != CODE_NONE) begin
            res.illegal = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_code_fifo.sv
// Synchronous circular-buffer FIFO with occupancy count. DEPTH must be a power of 2 so
// the pointers wrap naturally.
module sync_code_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             do_push, do_pop;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign level   = level_q;

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointer and occupancy update; push+pop together leaves the level unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop) begin
                level_q <= level_q + LVL_W'(1);
            end else if (do_pop && !do_push) begin
                level_q <= level_q - LVL_W'(1);
            end
        end
    end

endmodule

// File: rtl/onehot_decoder_drv.sv
// Replays a stream of 8-bit index codes as a timed one-hot sequence: codes are queued in a
// FIFO and each decoded pattern is held for hold_cycles (0 treated as 1) cycles.
// Defining ONEHOT_DRV_THERMO_EN adds thermo_mode for thermometer-style decode.
module onehot_decoder_drv
    import onehot_drv_pkg::*;
#(
    parameter int unsigned HOLD_W = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CODE_W-1:0]           code_in,
    input  logic                        code_valid,
    output logic                        code_ready,
    input  logic [HOLD_W-1:0]           hold_cycles,
    input  logic                        err_clr,
`ifdef ONEHOT_DRV_THERMO_EN
    input  logic                        thermo_mode,
`endif
    output logic [OUT_W-1:0]            onehot_out,
    output logic                        busy,
    output logic                        err_sticky,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]    onehot_q, onehot_d;
    logic                err_q, err_d;
    logic                pop;
    logic                thermo;
    decode_t             dec;
    logic [CODE_W-1:0]   fifo_rdata;
    logic                fifo_full, fifo_empty;

`ifdef ONEHOT_DRV_THERMO_EN
    assign thermo = thermo_mode;
`else
    assign thermo = 1'b0;
`endif

    sync_code_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(CODE_W)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (code_valid),
        .wdata(code_in),
        .pop  (pop),
        .rdata(fifo_rdata),
        .full (fifo_full),
        .empty(fifo_empty),
        .level(fifo_level)
    );

    assign dec        = decode_code(fifo_rdata, thermo);
    assign code_ready = !fifo_full;
    assign busy       = (state_q != IDLE) || !fifo_empty;
    assign onehot_out = onehot_q;
    assign err_sticky = err_q;

    // Next-state: pop whenever idle with data, or on the last hold cycle for back-to-back.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        onehot_d = onehot_q;
        err_d    = err_q;
        pop      = 1'b0;
        unique case (state_q)
            IDLE: begin
                onehot_d = '0;
                if (!fifo_empty) pop = 1'b1;
            end
            HOLD: begin
                if (cnt_q <= HOLD_W'(1)) begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        onehot_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q - HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            state_d  = HOLD;
            onehot_d = dec.pattern;
            cnt_d    = (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;
        end
        // A new error on the same edge as err_clr takes priority.
        if (err_clr) err_d = 1'b0;
        if (pop && dec.illegal) err_d = 1'b1;
    end

    // State, counter, output pattern and error flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            onehot_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            onehot_q <= onehot_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_onehot_decoder_drv.sv
// Self-checking bench: expected per-cycle patterns are queued as codes are driven and
// compared cycle by cycle as the DUT replays them.
module tb_onehot_decoder_drv;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  code_in;
    logic        code_valid;
    logic        code_ready;
    logic [7:0]  hold_cycles;
    logic        err_clr;
`ifdef ONEHOT_DRV_THERMO_EN
    logic        thermo_mode;
`endif
    logic [15:0] onehot_out;
    logic        busy;
    logic        err_sticky;
    logic [2:0]  fifo_level;

    logic [15:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;

    onehot_decoder_drv #(
        .HOLD_W(8),
        .FIFO_DEPTH(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .code_in    (code_in),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .hold_cycles(hold_cycles),
        .err_clr    (err_clr),
`ifdef ONEHOT_DRV_THERMO_EN
        .thermo_mode(thermo_mode),
`endif
        .onehot_out (onehot_out),
        .busy       (busy),
        .err_sticky (err_sticky),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model_pattern(input logic [7:0] c);
        if (c < 8'h10) return 16'h0001 << c[3:0];
        return 16'h0000;
    endfunction

    // Drive one code across a single edge and queue its expected per-cycle output.
    task automatic push_code(input logic [7:0] c, input logic [7:0] h);
        int eff;
        eff = (h == 0) ? 1 : int'(h);
        @(negedge clk);
        code_in     = c;
        hold_cycles = h;
        code_valid  = 1'b1;
        repeat (eff) exp_q.push_back(model_pattern(c));
        @(posedge clk);
        #1 code_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (onehot_out !== 16'h0) $display("FAIL reset_onehot got %h want 0000", onehot_out); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (err_sticky !== 1'b0) $display("FAIL reset_err got %b want 0", err_sticky); else n_pass++;
        n_checks++; if (fifo_level !== 3'd0) $display("FAIL reset_level got %0d want 0", fifo_level); else n_pass++;
        n_checks++; if (code_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", code_ready); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [15:0] e;
        fork
            push_code(8'h05, 8'd3);
            begin
                @(negedge clk); @(posedge clk);
                for (int i = 0; i < 3; i++) begin
                    @(posedge clk); #1;
                    n_checks++;
                    if (exp_q.size() == 0) $display("FAIL single_q got %h want <none>", onehot_out);
                    else begin
                        e = exp_q.pop_front();
                        if (onehot_out !== e) $display("FAIL single_out[%0d] got %h want %h", i, onehot_out, e);
                        else n_pass++;
                    end
                    n_checks++; if (busy !== 1'b1) $display("FAIL single_busy[%0d] got %b want 1", i, busy); else n_pass++;
                end
                @(posedge clk); #1;
                n_checks++; if (onehot_out !== 16'h0) $display("FAIL single_end got %h want 0000", onehot_out); else n_pass++;
                n_checks++; if (busy !== 1'b0) $display("FAIL single_busy_end got %b want 0", busy); else n_pass++;
                n_checks++; if (err_sticky !== 1'b0) $display("FAIL single_err got %b want 0", err_sticky); else n_pass++;
            end
        join
    endtask

    task automatic test_back_to_back();
        logic [15:0] e;
        fork
            begin
                push_code(8'h00, 8'd2);
                push_code(8'h0F, 8'd2);
                push_code(8'hF0, 8'd2);
                push_code(8'h07, 8'd2);
            end
            begin
                @(negedge clk); @(posedge clk);
                for (int i = 0; i < 8; i++) begin
                    @(posedge clk); #1;
                    n_checks++;
                    if (exp_q.size() == 0) $display("FAIL b2b_q got %h want <none>", onehot_out);
                    else begin
                        e = exp_q.pop_front();
                        if (onehot_out !== e) $display("FAIL b2b_out[%0d] got %h want %h", i, onehot_out, e);
                        else n_pass++;
                    end
                end
                @(posedge clk); #1;
                n_checks++; if (onehot_out !== 16'h0) $display("FAIL b2b_end got %h want 0000", onehot_out); else n_pass++;
                n_checks++; if (busy !== 1'b0) $display("FAIL b2b_busy_end got %b want 0", busy); else n_pass++;
            end
        join
    endtask

    task automatic test_full();
        logic [15:0] e;
        logic [7:0]  codes [4] = '{8'h01, 8'h02, 8'h04, 8'h08};
        fork
            begin
                push_code(8'h03, 8'd200);
                @(posedge clk);  // let the long hold be sampled before hold_cycles changes
                for (int k = 0; k < 4; k++) push_code(codes[k], 8'd1);
                @(negedge clk);
                code_in    = 8'h0C;
                code_valid = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    @(posedge clk); #1;
                    n_checks++; if (fifo_level !== 3'd4) $display("FAIL full_level[%0d] got %0d want 4", k, fifo_level); else n_pass++;
                    n_checks++; if (code_ready !== 1'b0) $display("FAIL full_ready[%0d] got %b want 0", k, code_ready); else n_pass++;
                end
                code_valid = 1'b0;
            end
            begin
                @(negedge clk); @(posedge clk);
                for (int i = 0; i < 204; i++) begin
                    @(posedge clk); #1;
                    n_checks++;
                    if (exp_q.size() == 0) $display("FAIL full_q got %h want <none>", onehot_out);
                    else begin
                        e = exp_q.pop_front();
                        if (onehot_out !== e) $display("FAIL full_out[%0d] got %h want %h", i, onehot_out, e);
                        else n_pass++;
                    end
                end
                @(posedge clk); #1;
                n_checks++; if (onehot_out !== 16'h0) $display("FAIL full_end got %h want 0000", onehot_out); else n_pass++;
                n_checks++; if (fifo_level !== 3'd0) $display("FAIL full_level_end got %0d want 0", fifo_level); else n_pass++;
            end
        join
    endtask

    task automatic test_error();
        logic [15:0] e;
        fork
            begin
                push_code(8'h2A, 8'd2);
                push_code(8'h01, 8'd2);
            end
            begin
                @(negedge clk); @(posedge clk);
                for (int i = 0; i < 4; i++) begin
                    @(posedge clk); #1;
                    n_checks++;
                    if (exp_q.size() == 0) $display("FAIL err_q got %h want <none>", onehot_out);
                    else begin
                        e = exp_q.pop_front();
                        if (onehot_out !== e) $display("FAIL err_out[%0d] got %h want %h", i, onehot_out, e);
                        else n_pass++;
                    end
                end
            end
        join
        n_checks++; if (err_sticky !== 1'b1) $display("FAIL err_set got %b want 1", err_sticky); else n_pass++;
        @(negedge clk); err_clr = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (err_sticky !== 1'b0) $display("FAIL err_clr got %b want 0", err_sticky); else n_pass++;
        err_clr = 1'b0;
        repeat (2) @(posedge clk);
        // Clear coincides with the pop of a second illegal code; the set must win.
        push_code(8'h2A, 8'd1);
        @(negedge clk); err_clr = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (err_sticky !== 1'b1) $display("FAIL err_set_wins got %b want 1", err_sticky); else n_pass++;
        n_checks++; if (onehot_out !== 16'h0) $display("FAIL err_none_out got %h want 0000", onehot_out); else n_pass++;
        err_clr = 1'b0;
        repeat (3) @(posedge clk);
        exp_q.delete();
        #1;
    endtask

    task automatic test_hold_zero();
        logic [15:0] e;
        fork
            begin
                push_code(8'h02, 8'd0);
                push_code(8'h04, 8'd0);
            end
            begin
                @(negedge clk); @(posedge clk);
                for (int i = 0; i < 2; i++) begin
                    @(posedge clk); #1;
                    n_checks++;
                    if (exp_q.size() == 0) $display("FAIL hold0_q got %h want <none>", onehot_out);
                    else begin
                        e = exp_q.pop_front();
                        if (onehot_out !== e) $display("FAIL hold0_out[%0d] got %h want %h", i, onehot_out, e);
                        else n_pass++;
                    end
                end
                @(posedge clk); #1;
                n_checks++; if (onehot_out !== 16'h0) $display("FAIL hold0_end got %h want 0000", onehot_out); else n_pass++;
            end
        join
    endtask

    task automatic test_reset_mid_hold();
        push_code(8'h06, 8'd50);
        push_code(8'h01, 8'd50);
        push_code(8'h02, 8'd50);
        push_code(8'h03, 8'd50);
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (onehot_out !== 16'h0040) $display("FAIL rstmid_pre_out got %h want 0040", onehot_out); else n_pass++;
        n_checks++; if (fifo_level !== 3'd3) $display("FAIL rstmid_pre_level got %0d want 3", fifo_level); else n_pass++;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (onehot_out !== 16'h0) $display("FAIL rstmid_out got %h want 0000", onehot_out); else n_pass++;
        n_checks++; if (fifo_level !== 3'd0) $display("FAIL rstmid_level got %0d want 0", fifo_level); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (code_ready !== 1'b1) $display("FAIL rstmid_ready got %b want 1", code_ready); else n_pass++;
        @(negedge clk); rst = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (onehot_out !== 16'h0) $display("FAIL rstmid_after got %h want 0000", onehot_out); else n_pass++;
    endtask

`ifdef ONEHOT_DRV_THERMO_EN
    task automatic test_thermo();
        thermo_mode = 1'b1;
        push_code(8'h03, 8'd2);
        exp_q.delete();
        @(posedge clk); #1;
        n_checks++; if (onehot_out !== 16'h000F) $display("FAIL thermo_out got %h want 000f", onehot_out); else n_pass++;
        repeat (3) @(posedge clk);
        thermo_mode = 1'b0;
    endtask
`endif

    initial begin
        rst         = 1'b1;
        code_in     = 8'h00;
        code_valid  = 1'b0;
        hold_cycles = 8'd1;
        err_clr     = 1'b0;
`ifdef ONEHOT_DRV_THERMO_EN
        thermo_mode = 1'b0;
`endif
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_error();
        test_hold_zero();
        test_reset_mid_hold();
`ifdef ONEHOT_DRV_THERMO_EN
        test_thermo();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
